// File: rtl/fp_normalize_round_pkg.sv
// Shared FP32 constants, the packed single-precision layout and the
// normalize/round sequencer states.
package fp_normalize_round_pkg;
   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;
   localparam int FP32_BIAS   = 127;
   localparam int EXP_MAX     = 255;
   localparam int RAW_MANT_W  = 28;
   // Internal exponent is signed and two bits wider so +1 carries past 255 stay visible
   localparam int IEXP_W      = 10;
   localparam logic signed [IEXP_W-1:0] IEXP_MAX = IEXP_W'(EXP_MAX);

   typedef struct packed {
      logic                   sign;
      logic [FP32_EXP_W-1:0]  exp;
      logic [FP32_FRAC_W-1:0] frac;
   } fp32_t;

   typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} nr_state_e;
endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream operand and downstream result handshakes of the normalize/round stage.
interface fp_normalize_round_if;
   import fp_normalize_round_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic                  in_sign;
   logic [FP32_EXP_W-1:0] in_exp;
   logic [RAW_MANT_W-1:0] in_mant;
   logic                  out_valid;
   logic                  out_ready;
   logic [31:0]           result;
   logic                  overflow;
   logic                  underflow;
   logic                  inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, result, overflow, underflow, inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, result, overflow, underflow, inexact
   );
endinterface

// File: rtl/fp_normalize_round_rne.sv
// Combinational round-to-nearest-even of a normalized (or denormal) 24-bit
// significand with guard/round/sticky, producing the packed exponent field.
module fp_round_rne
   import fp_normalize_round_pkg::*;
(
   input  logic [FP32_FRAC_W:0]      sig_i,
   input  logic [2:0]                grs_i,
   input  logic signed [IEXP_W-1:0]  exp_i,
   output logic [FP32_FRAC_W-1:0]    frac_o,
   output logic [FP32_EXP_W-1:0]     exp_o,
   output logic                      overflow_o,
   output logic                      inexact_o
);
   logic                        up;
   logic [FP32_FRAC_W+1:0]      sum;
   logic [FP32_FRAC_W:0]        sig_r;
   logic signed [IEXP_W-1:0]    exp_r;

   always_comb begin
      up  = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
      sum = {1'b0, sig_i} + {{(FP32_FRAC_W+1){1'b0}}, up};
      if (sum[FP32_FRAC_W+1]) begin
         sig_r = sum[FP32_FRAC_W+1:1];
         exp_r = exp_i + IEXP_W'(1);
      end else begin
         sig_r = sum[FP32_FRAC_W:0];
         exp_r = exp_i;
      end
      overflow_o = (exp_r >= IEXP_MAX);
      inexact_o  = (|grs_i) | overflow_o;
      if (overflow_o) begin
         frac_o = '0;
         exp_o  = '1;
      end else begin
         frac_o = sig_r[FP32_FRAC_W-1:0];
         // A clear hidden bit means denormal or zero; a denormal that rounded
         // into the hidden bit already carries exponent 1
         exp_o  = sig_r[FP32_FRAC_W] ? exp_r[FP32_EXP_W-1:0] : '0;
      end
   end
endmodule

// File: rtl/fp_normalize_round.sv
// Post-add normalize (one left shift per cycle) and RNE round stage of the
// FP32 adder; one operation in flight, valid/ready on both sides.
module fp_normalize_round
   import fp_normalize_round_pkg::*;
#(
   parameter int MANT_W = RAW_MANT_W,
   parameter int EXP_W  = FP32_EXP_W
) (
   input  logic                clk,
   input  logic                rst,
   fp_normalize_round_if.slave bus
);
   nr_state_e                state_q, state_d;
   logic                     sign_q, sign_d;
   logic signed [IEXP_W-1:0] exp_q, exp_d;
   logic [MANT_W-1:0]        mant_q, mant_d;
   logic                     special_q, special_d;
   fp32_t                    result_q, result_d;
   logic                     ovf_q, ovf_d;
   logic                     unf_q, unf_d;
   logic                     inx_q, inx_d;

   logic                     accept;
   logic [FP32_FRAC_W-1:0]   rnd_frac;
   logic [FP32_EXP_W-1:0]    rnd_exp;
   logic                     rnd_ovf;
   logic                     rnd_inx;

   assign bus.in_ready  = (state_q == IDLE) & ~rst;
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.inexact   = inx_q;

   fp_round_rne u_round (
      .sig_i      (mant_q[26:3]),
      .grs_i      (mant_q[2:0]),
      .exp_i      (exp_q),
      .frac_o     (rnd_frac),
      .exp_o      (rnd_exp),
      .overflow_o (rnd_ovf),
      .inexact_o  (rnd_inx)
   );

   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      special_d = special_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      inx_d     = inx_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = NORM;
               sign_d    = bus.in_sign;
               mant_d    = bus.in_mant;
               special_d = (bus.in_exp == '1);
               exp_d     = (bus.in_exp == '0) ? IEXP_W'(1)
                                              : {{(IEXP_W-EXP_W){1'b0}}, bus.in_exp};
            end
         end
         NORM: begin
            if (special_q || (mant_q == '0)) begin
               state_d = ROUND;
            end else if (mant_q[27]) begin
               // Carry out of the adder: the dropped bit folds into sticky
               mant_d  = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
               exp_d   = exp_q + IEXP_W'(1);
               state_d = ROUND;
            end else if (mant_q[26] || (exp_q == IEXP_W'(1))) begin
               state_d = ROUND;
            end else begin
               mant_d  = {mant_q[26:0], 1'b0};
               exp_d   = exp_q - IEXP_W'(1);
            end
         end
         ROUND: begin
            state_d = DONE;
            if (special_q) begin
               result_d = {sign_q, 8'hFF, mant_q[25:3]};
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
            end else if (mant_q == '0) begin
               result_d = '0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               inx_d    = 1'b0;
            end else begin
               result_d = {sign_q, rnd_exp, rnd_frac};
               ovf_d    = rnd_ovf;
               unf_d    = (rnd_exp == '0) & rnd_inx;
               inx_d    = rnd_inx;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
      end
   end

   // Operand datapath is only meaningful after an accept, so it is not reset
   always_ff @(posedge clk) begin
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      special_q <= special_d;
   end
endmodule
